mac_rtc_xpram: RTL and testbench

Parametrised RTC/XPRAM for the Mac core's VIA 3-wire serial clock interface, replacing the fixed 20/256-byte PRAM block. It keeps a free-running binary seconds counter with a 1 Hz tick, battery RAM of configurable depth, and a write-protect register. A host-side port lets the OSD/SD logic load and persist the RAM and clock.

---
 rtl/mac_rtc_xpram.sv | 203 ++++++++++++++++++++
 tb/tb_mac_rtc_xpram.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rtc_xpram.sv
// RTC/XPRAM for the Mac VIA 3-wire serial clock interface: binary seconds counter,
// battery RAM with write protect, and a host-side port for load/persist.
module mac_rtc_xpram #(
  parameter int CLK_HZ   = 32000000,
  parameter bit XPRAM_EN = 1'b1,
  parameter int RAM_AW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              _cs,
  input  logic              ck,
  input  logic              dat_i,
  output logic              dat_o,
  output logic              one_sec,
  input  logic [31:0]       secs_in,
  input  logic              secs_load,
  output logic [31:0]       secs_out,
  output logic              secs_wr,
  input  logic [RAM_AW-1:0] pram_a,
  input  logic [7:0]        pram_din,
  output logic [7:0]        pram_dout,
  input  logic              pram_wr,
  output logic [2:0]        dbg_state
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [2:0] {S_CMD, S_XADDR, S_WDATA, S_RDATA, S_DONE} state_t;
  typedef enum logic [1:0] {T_NONE, T_RAM, T_SECS, T_WP} tgt_t;

  state_t            state, state_next;
  tgt_t              tgt, tgt_next;
  logic              ck_d, rise, fall, byte_done;
  logic [2:0]        bit_cnt;
  logic [6:0]        in_sr;
  logic [7:0]        byte_val, out_sr, rsp_byte, wr_data, ram_q;
  logic [RAM_AW-1:0] ser_addr, addr_next;
  logic [1:0]        secs_sel, sel_next;
  logic              cmd_rd, cmd_rd_next;
  logic [2:0]        cmd_lo, cmd_lo_next;
  logic              ld_rsp, load_rsp, do_wr, ram_we, secs_we, wp;
  logic              dec_secs, dec_wp, dec_test, dec_ram, dec_ext;
  logic [7:0]        classic_addr;
  logic [PW-1:0]     presc;
  logic              tick;
  logic [31:0]       secs, secs_upd;
  logic [7:0]        ram [0:(1<<RAM_AW)-1];

  assign rise      = !_cs && !ck_d && ck;
  assign fall      = !_cs && ck_d && !ck;
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign byte_val  = {in_sr, dat_i};
  assign dbg_state = state;
  assign secs_out  = secs;

  // Command decode on the byte completing this cycle; patterns are mutually exclusive.
  assign dec_secs = (byte_val[6:5] == 2'b00) && (byte_val[1:0] == 2'b01) &&
                    (byte_val[7] || !byte_val[4]);
  assign dec_wp   = !byte_val[7] && (byte_val[6:0] == 7'b0110101);
  assign dec_test = !byte_val[7] && (byte_val[6:0] == 7'b0110001);
  assign dec_ram  = ((byte_val[6:4] == 3'b010) || byte_val[6]) && (byte_val[1:0] == 2'b01);
  assign dec_ext  = XPRAM_EN && (byte_val[6:3] == 4'b0111);
  assign classic_addr = byte_val[6] ? {4'h1, byte_val[5:2]} : {6'b000010, byte_val[3:2]};

  always_comb begin
    state_next  = state;
    tgt_next    = tgt;
    addr_next   = ser_addr;
    sel_next    = secs_sel;
    cmd_rd_next = cmd_rd;
    cmd_lo_next = cmd_lo;
    ld_rsp      = 1'b0;
    do_wr       = 1'b0;
    if (byte_done) begin
      case (state)
        S_CMD: begin
          cmd_rd_next = byte_val[7];
          cmd_lo_next = byte_val[2:0];
          if (dec_ext) begin
            state_next = S_XADDR;
          end else if (dec_secs || dec_ram) begin
            tgt_next   = dec_secs ? T_SECS : T_RAM;
            sel_next   = byte_val[3:2];
            addr_next  = RAM_AW'(classic_addr);
            state_next = byte_val[7] ? S_RDATA : S_WDATA;
            ld_rsp     = byte_val[7];
          end else if (dec_wp || dec_test) begin
            tgt_next   = dec_wp ? T_WP : T_NONE;
            state_next = S_WDATA;
          end else begin
            state_next = S_DONE;
          end
        end
        S_XADDR: begin
          tgt_next   = T_RAM;
          addr_next  = RAM_AW'({cmd_lo, byte_val[6:2]});
          state_next = cmd_rd ? S_RDATA : S_WDATA;
          ld_rsp     = cmd_rd;
        end
        S_WDATA: begin
          do_wr      = 1'b1;
          state_next = S_DONE;
        end
        S_RDATA: state_next = S_DONE;
        default: state_next = S_DONE;
      endcase
    end
  end

  assign rsp_byte = (tgt == T_SECS) ? secs[{secs_sel, 3'b000} +: 8] : ram_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ck_d     <= 1'b0;
      bit_cnt  <= 3'd0;
      in_sr    <= 7'd0;
      state    <= S_CMD;
      tgt      <= T_NONE;
      ser_addr <= '0;
      secs_sel <= 2'd0;
      cmd_rd   <= 1'b0;
      cmd_lo   <= 3'd0;
      out_sr   <= 8'hFF;
      dat_o    <= 1'b1;
      load_rsp <= 1'b0;
      ram_we   <= 1'b0;
      secs_we  <= 1'b0;
      wr_data  <= 8'd0;
      wp       <= 1'b0;
    end else begin
      ram_we   <= do_wr && (tgt == T_RAM) && !wp;
      secs_we  <= do_wr && (tgt == T_SECS);
      load_rsp <= ld_rsp;
      tgt      <= tgt_next;
      ser_addr <= addr_next;
      secs_sel <= sel_next;
      cmd_rd   <= cmd_rd_next;
      cmd_lo   <= cmd_lo_next;
      if (do_wr) wr_data <= byte_val;
      if (do_wr && (tgt == T_WP)) wp <= byte_val[7];
      if (_cs) begin
        bit_cnt <= 3'd0;
        in_sr   <= 7'd0;
        state   <= S_CMD;
        out_sr  <= 8'hFF;
        dat_o   <= 1'b1;
      end else begin
        ck_d  <= ck;
        state <= state_next;
        if (rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          in_sr   <= byte_val[6:0];
        end
        // Drained bits are back-filled with 1 so the line idles high after a response.
        if (load_rsp) begin
          out_sr <= rsp_byte;
        end else if (fall) begin
          dat_o  <= out_sr[7];
          out_sr <= {out_sr[6:0], 1'b1};
        end
      end
    end
  end

  assign tick = (presc == PW'(CLK_HZ - 1));

  always_comb begin
    secs_upd = secs + {31'd0, tick};
    if (secs_we) secs_upd[{secs_sel, 3'b000} +: 8] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      secs    <= 32'd0;
      one_sec <= 1'b0;
      secs_wr <= 1'b0;
    end else if (secs_load) begin
      presc   <= '0;
      secs    <= secs_in;
      one_sec <= 1'b0;
      secs_wr <= 1'b0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      secs    <= secs_upd;
      one_sec <= tick;
      secs_wr <= secs_we;
    end
  end

  // Serial port reads the next address so a response can be latched one clk later.
  always_ff @(posedge clk) begin
    if (ram_we && !reset && !(pram_wr && (pram_a == ser_addr))) ram[ser_addr] <= wr_data;
    if (pram_wr) ram[pram_a] <= pram_din;
    ram_q <= ram[addr_next];
  end

  always_ff @(posedge clk) begin
    if (reset) pram_dout <= 8'd0;
    else       pram_dout <= ram[pram_a];
  end

endmodule

// File: tb/tb_mac_rtc_xpram.sv
// Bench for mac_rtc_xpram: one XPRAM instance with a slow prescaler and one classic
// instance with CLK_HZ=4, sharing the serial and host stimulus.
module tb_mac_rtc_xpram;

  localparam int K_XFER = 0, K_HWR = 1, K_HRD = 2, K_LOAD = 3, K_SECS = 4;

  typedef struct {
    int          kind;
    int          nw;
    logic [7:0]  b0, b1, b2;
    bit          rd;
    logic [7:0]  exp_a, exp_b;
    bit          chk_b;
    logic [31:0] val;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, cs_n, ck, dat_i, secs_load, pram_wr;
  logic [31:0] secs_in;
  logic [7:0]  pram_a, pram_din;

  logic        dat_o_a, one_sec_a, secs_wr_a, dat_o_b, one_sec_b, secs_wr_b;
  logic [31:0] secs_out_a, secs_out_b;
  logic [7:0]  pram_dout_a, pram_dout_b;
  logic [2:0]  dbg_a, dbg_b;

  int n_vec = 0;
  int n_miss = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  logic [16:0] exp_q[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  mac_rtc_xpram #(.CLK_HZ(1000000), .XPRAM_EN(1'b1), .RAM_AW(8)) dut_a (
    .clk(clk), .reset(reset), ._cs(cs_n), .ck(ck), .dat_i(dat_i), .dat_o(dat_o_a),
    .one_sec(one_sec_a), .secs_in(secs_in), .secs_load(secs_load), .secs_out(secs_out_a),
    .secs_wr(secs_wr_a), .pram_a(pram_a), .pram_din(pram_din), .pram_dout(pram_dout_a),
    .pram_wr(pram_wr), .dbg_state(dbg_a)
  );

  mac_rtc_xpram #(.CLK_HZ(4), .XPRAM_EN(1'b0), .RAM_AW(5)) dut_b (
    .clk(clk), .reset(reset), ._cs(cs_n), .ck(ck), .dat_i(dat_i), .dat_o(dat_o_b),
    .one_sec(one_sec_b), .secs_in(secs_in), .secs_load(secs_load), .secs_out(secs_out_b),
    .secs_wr(secs_wr_b), .pram_a(pram_a[4:0]), .pram_din(pram_din), .pram_dout(pram_dout_b),
    .pram_wr(pram_wr), .dbg_state(dbg_b)
  );

  always @(posedge clk) begin
    if (!reset && secs_wr_a) wr_cnt_a++;
    if (!reset && secs_wr_b) wr_cnt_b++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One serial bit: data set up, rise, then fall; each level held 2..4 clk.
  task automatic ser_bit(input logic b);
    dat_i = b;
    ck = 1'b1;
    idle($urandom_range(2, 4));
    ck = 1'b0;
    idle($urandom_range(2, 4));
  endtask

  task automatic ser_wbyte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) ser_bit(b[i]);
  endtask

  task automatic ser_rbyte(output logic [7:0] ra, output logic [7:0] rb);
    for (int i = 7; i >= 0; i--) begin
      ra[i] = dat_o_a;
      rb[i] = dat_o_b;
      ser_bit(1'b1);
    end
  endtask

  task automatic host_read(input string name, input logic [7:0] a,
                           input logic [7:0] ea, input logic [7:0] eb);
    pram_a = a;
    @(negedge clk);
    check({name, " dout_a"}, {24'd0, pram_dout_a}, {24'd0, ea});
    check({name, " dout_b"}, {24'd0, pram_dout_b}, {24'd0, eb});
  endtask

  function automatic vec_t mk(input int kind, input int nw, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2, input bit rd,
                              input logic [7:0] ea, input logic [7:0] eb, input bit cb,
                              input logic [31:0] val);
    vec_t v;
    v.kind = kind; v.nw = nw; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.rd = rd;
    v.exp_a = ea; v.exp_b = eb; v.chk_b = cb; v.val = val;
    return v;
  endfunction

  initial begin
    logic [7:0]  ra, rb, wb;
    logic [16:0] e;
    int          n;

    reset = 1'b1; cs_n = 1'b1; ck = 1'b0; dat_i = 1'b0; secs_load = 1'b0;
    secs_in = 32'd0; pram_a = 8'd0; pram_din = 8'd0; pram_wr = 1'b0;
    idle(3);
    reset = 1'b0;
    check("rst dat_o_a", {31'd0, dat_o_a}, 32'd1);
    check("rst dat_o_b", {31'd0, dat_o_b}, 32'd1);
    check("rst one_sec", {31'd0, one_sec_a}, 32'd0);
    check("rst secs_wr", {31'd0, secs_wr_a}, 32'd0);
    check("rst secs_out", secs_out_a, 32'd0);
    check("rst pram_dout", {24'd0, pram_dout_a}, 32'd0);
    check("rst state", {29'd0, dbg_a}, 32'd0);

    // kind, nw, b0, b1, b2, rd, exp_a, exp_b, chk_b, val
    vt.push_back(mk(K_HWR,  0, 8'h10, 8'h33, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_HWR,  0, 8'h01, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 2, 8'h35, 8'h80, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 2, 8'h41, 8'hAA, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_HRD,  0, 8'h10, 8'h00, 8'h00, 0, 8'h33, 8'h33, 1, 0));
    vt.push_back(mk(K_XFER, 2, 8'h35, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 2, 8'h41, 8'hAA, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_HRD,  0, 8'h10, 8'h00, 8'h00, 0, 8'hAA, 8'hAA, 1, 0));
    vt.push_back(mk(K_XFER, 1, 8'hC1, 8'h00, 8'h00, 1, 8'hAA, 8'hAA, 1, 0));
    vt.push_back(mk(K_XFER, 2, 8'h25, 8'hC3, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_HRD,  0, 8'h09, 8'h00, 8'h00, 0, 8'hC3, 8'hC3, 1, 0));
    vt.push_back(mk(K_LOAD, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 32'h12345678));
    vt.push_back(mk(K_XFER, 1, 8'h81, 8'h00, 8'h00, 1, 8'h78, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 1, 8'h85, 8'h00, 8'h00, 1, 8'h56, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 1, 8'h89, 8'h00, 8'h00, 1, 8'h34, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 1, 8'h8D, 8'h00, 8'h00, 1, 8'h12, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 1, 8'h91, 8'h00, 8'h00, 1, 8'h78, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 2, 8'h01, 8'hAB, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_SECS, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 32'h123456AB));
    vt.push_back(mk(K_XFER, 2, 8'h11, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_SECS, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 32'h123456AB));
    vt.push_back(mk(K_XFER, 3, 8'h38, 8'h04, 8'h5A, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_HRD,  0, 8'h01, 8'h00, 8'h00, 0, 8'h5A, 8'h00, 1, 0));
    vt.push_back(mk(K_XFER, 2, 8'hB8, 8'h04, 8'h00, 1, 8'h5A, 8'hFF, 1, 0));
    vt.push_back(mk(K_XFER, 1, 8'hFF, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 1, 0));
    vt.push_back(mk(K_XFER, 2, 8'h31, 8'h77, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk(K_XFER, 1, 8'hC1, 8'h00, 8'h00, 1, 8'hAA, 8'hAA, 1, 0));

    foreach (vt[i]) begin
      case (vt[i].kind)
        K_HWR: begin
          pram_a = vt[i].b0; pram_din = vt[i].b1; pram_wr = 1'b1;
          @(negedge clk);
          pram_wr = 1'b0;
        end
        K_HRD: host_read($sformatf("v%0d", i), vt[i].b0, vt[i].exp_a, vt[i].exp_b);
        K_LOAD: begin
          secs_in = vt[i].val; secs_load = 1'b1;
          @(negedge clk);
          secs_load = 1'b0;
          @(negedge clk);
        end
        K_SECS: check($sformatf("v%0d secs_out", i), secs_out_a, vt[i].val);
        default: begin
          if (vt[i].rd) exp_q.push_back({vt[i].chk_b, vt[i].exp_a, vt[i].exp_b});
          cs_n = 1'b0;
          idle(2);
          ser_wbyte(vt[i].b0);
          if (vt[i].nw > 1) ser_wbyte(vt[i].b1);
          if (vt[i].nw > 2) ser_wbyte(vt[i].b2);
          if (vt[i].rd) begin
            ser_rbyte(ra, rb);
            e = exp_q.pop_front();
            check($sformatf("v%0d rd_a", i), {24'd0, ra}, {24'd0, e[15:8]});
            if (e[16]) check($sformatf("v%0d rd_b", i), {24'd0, rb}, {24'd0, e[7:0]});
          end
          cs_n = 1'b1;
          idle(3);
        end
      endcase
    end
    check("secs_wr pulses a", wr_cnt_a, 1);
    check("secs_wr pulses b", wr_cnt_b, 1);
    check("scoreboard drained", exp_q.size(), 0);

    // Abort a data byte after 5 bits: no write, then a normal transfer.
    cs_n = 1'b0; idle(2);
    ser_wbyte(8'h41);
    for (int i = 0; i < 5; i++) ser_bit(1'b0);
    cs_n = 1'b1; idle(3);
    check("abort dat_o", {31'd0, dat_o_a}, 32'd1);
    host_read("abort keep", 8'h10, 8'hAA, 8'hAA);
    cs_n = 1'b0; idle(2);
    ser_wbyte(8'h41); ser_wbyte(8'h55);
    cs_n = 1'b1; idle(3);
    host_read("after abort", 8'h10, 8'h55, 8'h55);

    // Host and serial write RAM[0x11] in the same clk: host data must survive.
    cs_n = 1'b0; idle(2);
    ser_wbyte(8'h45);
    wb = 8'h22;
    for (int i = 7; i >= 1; i--) ser_bit(wb[i]);
    dat_i = wb[0]; ck = 1'b1;
    @(negedge clk);
    pram_a = 8'h11; pram_din = 8'h11; pram_wr = 1'b1;
    @(negedge clk);
    pram_wr = 1'b0;
    idle(1);
    ck = 1'b0; idle(2);
    cs_n = 1'b1; idle(3);
    host_read("collide", 8'h11, 8'h11, 8'h11);

    // Seconds wrap and 1 Hz period on the CLK_HZ=4 instance.
    secs_in = 32'hFFFF_FFFF; secs_load = 1'b1;
    @(negedge clk);
    secs_load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (n < 20) begin
        @(posedge clk); #1;
        n++;
        if (one_sec_b) break;
      end
      check($sformatf("one_sec period %0d", k), n, 4);
      check($sformatf("wrap secs %0d", k), secs_out_b, k);
    end
    @(negedge clk);
    check("slow secs held", secs_out_a, 32'hFFFF_FFFF);

    // Reset in the middle of a data byte, then decode again with _cs still low.
    cs_n = 1'b0; idle(2);
    ser_wbyte(8'h41);
    for (int i = 0; i < 4; i++) ser_bit(1'b1);
    reset = 1'b1; idle(2);
    reset = 1'b0;
    check("midrst secs", secs_out_a, 32'd0);
    check("midrst dat_o", {31'd0, dat_o_a}, 32'd1);
    ser_wbyte(8'h41); ser_wbyte(8'h66);
    cs_n = 1'b1; idle(3);
    host_read("after midrst", 8'h10, 8'h66, 8'h66);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
